// File: rtl/counter_ctrl.sv
// rtl/counter_ctrl.sv - sequencer driving one external counter through one-shot, periodic or ping-pong runs.
// Optional prescaled count tick enabled by defining CNT_CTRL_PRESCALE_EN.
module counter_ctrl #(
    parameter int COUNTER_SIZE = 32,
    parameter int PRESCALE_W   = 8
) (
    input  logic                    clk,
    input  logic                    res_n,
    input  logic                    start,
    input  logic                    stop,
    input  logic [1:0]              mode,
    input  logic [COUNTER_SIZE-1:0] init_val,
    input  logic [COUNTER_SIZE-1:0] target_val,
    input  logic [PRESCALE_W-1:0]   prescale,
    input  logic [COUNTER_SIZE-1:0] cnt_out,
    output logic                    cnt_enable,
    output logic                    cnt_load,
    output logic                    cnt_dir,
    output logic [COUNTER_SIZE-1:0] cnt_in,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_PERIODIC = 2'b01;
    localparam logic [1:0] MODE_PINGPONG = 2'b10;

    state_t                  state_q, state_d;
    logic [COUNTER_SIZE-1:0] init_q, init_d;
    logic [COUNTER_SIZE-1:0] target_q, target_d;
    logic [1:0]              mode_q, mode_d;
    logic                    dir_q, dir_d;
    logic                    phase_q, phase_d;
    logic                    done_q, done_d;
    logic                    hit;
    logic                    tick;

    // phase_q is set only on the return leg of a ping-pong run, where INIT is the endpoint
    assign hit = (state_q == ST_RUN) &&
                 (phase_q ? (cnt_out == init_q) : (cnt_out == target_q));

`ifdef CNT_CTRL_PRESCALE_EN
    logic [PRESCALE_W-1:0] div_q, div_d;

    assign tick = (div_q == prescale);

    always_comb begin
        div_d = div_q;
        if (state_q == ST_LOAD) begin
            div_d = '0;
        end else if (state_q == ST_RUN) begin
            if (hit || tick) begin
                div_d = '0;
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end
`else
    logic unused_prescale;

    assign tick            = 1'b1;
    assign unused_prescale = ^prescale;
`endif

    always_comb begin
        state_d    = state_q;
        init_d     = init_q;
        target_d   = target_q;
        mode_d     = mode_q;
        dir_d      = dir_q;
        phase_d    = phase_q;
        done_d     = 1'b0;
        cnt_enable = 1'b0;
        cnt_load   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d  = ST_LOAD;
                    init_d   = init_val;
                    target_d = target_val;
                    mode_d   = mode;
                    dir_d    = (init_val > target_val);
                    phase_d  = 1'b0;
                end
            end
            ST_LOAD: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_load = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (hit) begin
                    // an endpoint hit on back-to-back cycles (INIT == TARGET) still yields separate pulses
                    done_d = !done_q;
                    case (mode_q)
                        MODE_PERIODIC: cnt_load = 1'b1;
                        MODE_PINGPONG: begin
                            dir_d   = !dir_q;
                            phase_d = !phase_q;
                        end
                        default:       state_d = ST_IDLE;
                    endcase
                end else begin
                    cnt_enable = tick;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q  <= ST_IDLE;
            init_q   <= '0;
            target_q <= '0;
            mode_q   <= '0;
            dir_q    <= 1'b0;
            phase_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            init_q   <= init_d;
            target_q <= target_d;
            mode_q   <= mode_d;
            dir_q    <= dir_d;
            phase_q  <= phase_d;
            done_q   <= done_d;
        end
    end

    assign cnt_dir = dir_q;
    assign cnt_in  = init_q;
    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// tb/tb_counter_ctrl.sv - vector table and scoreboard bench for counter_ctrl with a behavioural counter.
module tb_counter_ctrl;

    localparam int CS = 32;

    logic          clk = 1'b0;
    logic          res_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [CS-1:0] init_val = '0;
    logic [CS-1:0] target_val = '0;
    logic [7:0]    prescale = 8'd0;
    logic [CS-1:0] cnt_out = 32'd9;
    logic          cnt_enable, cnt_load, cnt_dir, busy, done;
    logic [CS-1:0] cnt_in;

    typedef struct {
        logic          i_start;
        logic          i_stop;
        logic [1:0]    i_mode;
        logic [CS-1:0] i_init;
        logic [CS-1:0] i_tgt;
        logic          e_load;
        logic          e_en;
        logic          e_dir;
        logic          e_busy;
        logic          e_done;
        logic [CS-1:0] e_cnt;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   vec_idx = 0;

    counter_ctrl #(.COUNTER_SIZE(CS), .PRESCALE_W(8)) dut (
        .clk        (clk),
        .res_n      (res_n),
        .start      (start),
        .stop       (stop),
        .mode       (mode),
        .init_val   (init_val),
        .target_val (target_val),
        .prescale   (prescale),
        .cnt_out    (cnt_out),
        .cnt_enable (cnt_enable),
        .cnt_load   (cnt_load),
        .cnt_dir    (cnt_dir),
        .cnt_in     (cnt_in),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // external counter: registered load/count, load beats enable
    always @(posedge clk) begin
        if (cnt_load) cnt_out <= cnt_in;
        else if (cnt_enable) cnt_out <= cnt_dir ? cnt_out - 1'b1 : cnt_out + 1'b1;
    end

    function automatic vec_t mk(input logic st, input logic sp, input logic [1:0] md,
                                input logic [CS-1:0] iv, input logic [CS-1:0] tv,
                                input logic ld, input logic en, input logic dr,
                                input logic bs, input logic dn, input logic [CS-1:0] cn);
        vec_t v;
        v.i_start = st; v.i_stop = sp; v.i_mode = md; v.i_init = iv; v.i_tgt = tv;
        v.e_load = ld; v.e_en = en; v.e_dir = dr; v.e_busy = bs; v.e_done = dn; v.e_cnt = cn;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [CS-1:0] act, input logic [CS-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s vec %0d: got %0d, expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        vec_t e;
        @(negedge clk);
        start      = v.i_start;
        stop       = v.i_stop;
        mode       = v.i_mode;
        init_val   = v.i_init;
        target_val = v.i_tgt;
        sb.push_back(v);
        #1;
        e = sb.pop_front();
        chk("cnt_load",   vec_idx, {31'd0, cnt_load},   {31'd0, e.e_load});
        chk("cnt_enable", vec_idx, {31'd0, cnt_enable}, {31'd0, e.e_en});
        chk("cnt_dir",    vec_idx, {31'd0, cnt_dir},    {31'd0, e.e_dir});
        chk("busy",       vec_idx, {31'd0, busy},       {31'd0, e.e_busy});
        chk("done",       vec_idx, {31'd0, done},       {31'd0, e.e_done});
        chk("cnt_out",    vec_idx, cnt_out,             e.e_cnt);
        vec_idx++;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cnt_load"},   vec_idx, {31'd0, cnt_load},   '0);
        chk({tag, "_cnt_enable"}, vec_idx, {31'd0, cnt_enable}, '0);
        chk({tag, "_cnt_dir"},    vec_idx, {31'd0, cnt_dir},    '0);
        chk({tag, "_busy"},       vec_idx, {31'd0, busy},       '0);
        chk({tag, "_done"},       vec_idx, {31'd0, done},       '0);
        chk({tag, "_cnt_in"},     vec_idx, cnt_in,              '0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        res_n = 1'b1;

        //            st sp md init tgt   ld en dr bs dn cnt
        // one-shot up 0 -> 5
        tbl.push_back(mk(1, 0, 0, 0,  5,   0, 0, 0, 0, 0, 9));
        tbl.push_back(mk(0, 0, 0, 0,  0,   1, 0, 0, 1, 0, 9));
        tbl.push_back(mk(0, 0, 0, 0,  0,   0, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  0,   0, 1, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0,  0,   0, 1, 0, 1, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0,  0,   0, 1, 0, 1, 0, 3));
        tbl.push_back(mk(0, 0, 0, 0,  0,   0, 1, 0, 1, 0, 4));
        tbl.push_back(mk(0, 0, 0, 0,  0,   0, 0, 0, 1, 0, 5));
        tbl.push_back(mk(0, 0, 0, 0,  0,   0, 0, 0, 0, 1, 5));
        tbl.push_back(mk(0, 0, 0, 0,  0,   0, 0, 0, 0, 0, 5));
        // periodic 2 -> 4, stopped after second reload
        tbl.push_back(mk(1, 0, 1, 2,  4,   0, 0, 0, 0, 0, 5));
        tbl.push_back(mk(0, 0, 0, 0,  0,   1, 0, 0, 1, 0, 5));
        tbl.push_back(mk(0, 0, 0, 0,  0,   0, 1, 0, 1, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0,  0,   0, 1, 0, 1, 0, 3));
        tbl.push_back(mk(0, 0, 0, 0,  0,   1, 0, 0, 1, 0, 4));
        tbl.push_back(mk(0, 0, 0, 0,  0,   0, 1, 0, 1, 1, 2));
        tbl.push_back(mk(0, 0, 0, 0,  0,   0, 1, 0, 1, 0, 3));
        tbl.push_back(mk(0, 0, 0, 0,  0,   1, 0, 0, 1, 0, 4));
        tbl.push_back(mk(0, 1, 0, 0,  0,   0, 0, 0, 1, 1, 2));
        tbl.push_back(mk(0, 0, 0, 0,  0,   0, 0, 0, 0, 0, 2));
        // ping-pong 1 <-> 3, stop lands on an endpoint hit
        tbl.push_back(mk(1, 0, 2, 1,  3,   0, 0, 0, 0, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0,  0,   1, 0, 0, 1, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0,  0,   0, 1, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0,  0,   0, 1, 0, 1, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0,  0,   0, 0, 0, 1, 0, 3));
        tbl.push_back(mk(0, 0, 0, 0,  0,   0, 1, 1, 1, 1, 3));
        tbl.push_back(mk(0, 0, 0, 0,  0,   0, 1, 1, 1, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0,  0,   0, 0, 1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0,  0,   0, 1, 0, 1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0,  0,   0, 1, 0, 1, 0, 2));
        tbl.push_back(mk(0, 1, 0, 0,  0,   0, 0, 0, 1, 0, 3));
        tbl.push_back(mk(0, 0, 0, 0,  0,   0, 0, 0, 0, 0, 3));

        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);

        // down count 10 -> 7 with a start while busy
        run_vec(mk(1, 0, 0, 10, 7,   0, 0, 0, 0, 0, 3));
        run_vec(mk(0, 0, 0, 0,  0,   1, 0, 1, 1, 0, 3));
        run_vec(mk(1, 0, 1, 0,  0,   0, 1, 1, 1, 0, 10));
        run_vec(mk(0, 0, 0, 0,  0,   0, 1, 1, 1, 0, 9));
        run_vec(mk(0, 0, 0, 0,  0,   0, 1, 1, 1, 0, 8));
        run_vec(mk(0, 0, 0, 0,  0,   0, 0, 1, 1, 0, 7));
        run_vec(mk(0, 0, 0, 0,  0,   0, 0, 1, 0, 1, 7));

        // INIT == TARGET with reserved mode behaves as one-shot
        run_vec(mk(1, 0, 3, 20, 20,  0, 0, 1, 0, 0, 7));
        run_vec(mk(0, 0, 0, 0,  0,   1, 0, 0, 1, 0, 7));
        run_vec(mk(0, 0, 0, 0,  0,   0, 0, 0, 1, 0, 20));
        run_vec(mk(0, 0, 0, 0,  0,   0, 0, 0, 0, 1, 20));

        // start together with stop in IDLE stays IDLE
        run_vec(mk(1, 1, 0, 5,  8,   0, 0, 0, 0, 0, 20));
        run_vec(mk(0, 0, 0, 0,  0,   0, 0, 0, 0, 0, 20));

        // periodic INIT == TARGET: done every second cycle
        run_vec(mk(1, 0, 1, 15, 15,  0, 0, 0, 0, 0, 20));
        run_vec(mk(0, 0, 0, 0,  0,   1, 0, 0, 1, 0, 20));
        run_vec(mk(0, 0, 0, 0,  0,   1, 0, 0, 1, 0, 15));
        run_vec(mk(0, 0, 0, 0,  0,   1, 0, 0, 1, 1, 15));
        run_vec(mk(0, 0, 0, 0,  0,   1, 0, 0, 1, 0, 15));
        run_vec(mk(0, 0, 0, 0,  0,   1, 0, 0, 1, 1, 15));
        run_vec(mk(0, 1, 0, 0,  0,   0, 0, 0, 1, 0, 15));
        run_vec(mk(0, 0, 0, 0,  0,   0, 0, 0, 0, 0, 15));

        // asynchronous reset in the middle of a down run
        run_vec(mk(1, 0, 0, 40, 30,  0, 0, 0, 0, 0, 15));
        run_vec(mk(0, 0, 0, 0,  0,   1, 0, 1, 1, 0, 15));
        run_vec(mk(0, 0, 0, 0,  0,   0, 1, 1, 1, 0, 40));
        run_vec(mk(0, 0, 0, 0,  0,   0, 1, 1, 1, 0, 39));
        #2;
        res_n = 1'b0;
        #1;
        chk_reset_outputs("midrun_reset");
        @(negedge clk);
        res_n = 1'b1;
        run_vec(mk(0, 0, 0, 0,  0,   0, 0, 0, 0, 0, 39));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
